display_frame_sequencer: RTL and testbench

Frame-refresh scheduler between the framebuffer memory reader and the 8080 display controller. It issues one read command per display line from the active framebuffer base address and keeps a bounded number of lines in flight. It passes the returned 16-bit pixels to the display controller's AXI stream and marks the last pixel of each frame with tlast. A double-buffer swap is applied only at frame boundaries, so the panel never shows a torn frame.

---
 rtl/display_pkg.sv | 18 +
 rtl/display_pixel_position.sv | 54 +++++
 rtl/display_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_display_frame_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display constants, the line byte-count helper and the sequencer state type.
package display_pkg;

  localparam int unsigned DISPLAY_X_RES = 320;
  localparam int unsigned DISPLAY_Y_RES = 240;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2
  } seq_state_e;

  // 16-bit pixels, so a line occupies two bytes per pixel.
  function automatic logic [15:0] LINE_BYTES(input int unsigned x_res);
    return 16'(x_res * 2);
  endfunction

endpackage

// File: rtl/display_pixel_position.sv
// Column/row position of accepted pixels within a frame, with line-wrap and last-pixel flags.
module display_pixel_position
  import display_pkg::*;
#(
  parameter int unsigned X_RES = DISPLAY_X_RES,
  parameter int unsigned Y_RES = DISPLAY_Y_RES,
  localparam int unsigned COL_W = $clog2(X_RES),
  localparam int unsigned ROW_W = $clog2(Y_RES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             advance_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             line_wrap_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_end, row_end;

  assign col_end = (col_q == COL_W'(X_RES - 1));
  assign row_end = (row_q == ROW_W'(Y_RES - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (advance_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o       = col_q;
  assign row_o       = row_q;
  assign line_wrap_o = advance_i && col_end;
  assign last_o      = col_end && row_end;

endmodule

// File: rtl/display_frame_sequencer.sv
// Issues one framebuffer read per display line, forwards returned pixels with a frame tlast,
// and applies double-buffer swaps only between frames.
module display_frame_sequencer
  import display_pkg::*;
#(
  parameter int unsigned X_RES           = DISPLAY_X_RES,
  parameter int unsigned Y_RES           = DISPLAY_Y_RES,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic                  fb_swap,
  output logic                  fb_swapped,
  output logic                  busy,
  output logic                  m_rd_valid,
  input  logic                  m_rd_ready,
  output logic [ADDR_WIDTH-1:0] m_rd_addr,
  output logic [15:0]           m_rd_len,
  input  logic                  s_pix_tvalid,
  output logic                  s_pix_tready,
  input  logic [15:0]           s_pix_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           m_axis_tdata
);

  localparam int unsigned COL_W  = $clog2(X_RES);
  localparam int unsigned ROW_W  = $clog2(Y_RES);
  localparam int unsigned LCNT_W = $clog2(Y_RES + 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(LINE_BYTES(X_RES));

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [ADDR_WIDTH-1:0] active_base_q, active_base_d;
  logic [ADDR_WIDTH-1:0] pending_addr_q, pending_addr_d;
  logic                  pending_valid_q, pending_valid_d;
  logic                  fb_valid_q, fb_valid_d;
  logic [LCNT_W-1:0]     lines_issued_q, lines_issued_d;
  logic [2:0]            outstanding_q, outstanding_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  swapped_q, swapped_d;

  logic             rd_fire, pix_accept, line_wrap, last_pixel, frame_done, start_frame;
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;

  assign rd_fire    = rd_valid_q && m_rd_ready;
  assign pix_accept = s_pix_tvalid && m_axis_tready;
  assign frame_done = pix_accept && last_pixel;

  display_pixel_position #(
    .X_RES(X_RES),
    .Y_RES(Y_RES)
  ) u_position (
    .clk_i      (aclk),
    .rst_ni     (resetn),
    .advance_i  (pix_accept),
    .col_o      (pix_col),
    .row_o      (pix_row),
    .line_wrap_o(line_wrap),
    .last_o     (last_pixel)
  );

  // A swap arriving in the same cycle as a frame start lands in pending for the following frame.
  always_comb begin
    state_d         = state_q;
    line_addr_d     = line_addr_q;
    active_base_d   = active_base_q;
    pending_addr_d  = pending_addr_q;
    pending_valid_d = pending_valid_q;
    fb_valid_d      = fb_valid_q;
    lines_issued_d  = lines_issued_q;
    swapped_d       = 1'b0;
    start_frame     = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (enable && fb_valid_q) start_frame = 1'b1;
      end
      SEQ_RUN: begin
        if (rd_fire) begin
          line_addr_d    = line_addr_q + LINE_STEP;
          lines_issued_d = lines_issued_q + 1'b1;
          if (lines_issued_d == LCNT_W'(Y_RES)) state_d = SEQ_DRAIN;
        end
      end
      SEQ_DRAIN: begin
        if (frame_done) begin
          if (enable) start_frame = 1'b1;
          else        state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    if (start_frame) begin
      state_d        = SEQ_RUN;
      lines_issued_d = '0;
      if (pending_valid_q) begin
        active_base_d   = pending_addr_q;
        line_addr_d     = pending_addr_q;
        pending_valid_d = 1'b0;
        swapped_d       = 1'b1;
      end else begin
        line_addr_d = active_base_q;
      end
    end

    if (fb_swap) begin
      pending_addr_d  = fb_addr;
      pending_valid_d = 1'b1;
      fb_valid_d      = 1'b1;
    end

    outstanding_d = outstanding_q + {2'b00, rd_fire} - {2'b00, line_wrap};
    rd_valid_d    = (rd_valid_q && !m_rd_ready) ||
                    ((state_q == SEQ_RUN) &&
                     (lines_issued_d < LCNT_W'(Y_RES)) &&
                     (outstanding_d < 3'(MAX_OUTSTANDING)));
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= SEQ_IDLE;
      line_addr_q     <= '0;
      active_base_q   <= '0;
      pending_addr_q  <= '0;
      pending_valid_q <= 1'b0;
      fb_valid_q      <= 1'b0;
      lines_issued_q  <= '0;
      outstanding_q   <= '0;
      rd_valid_q      <= 1'b0;
      swapped_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      line_addr_q     <= line_addr_d;
      active_base_q   <= active_base_d;
      pending_addr_q  <= pending_addr_d;
      pending_valid_q <= pending_valid_d;
      fb_valid_q      <= fb_valid_d;
      lines_issued_q  <= lines_issued_d;
      outstanding_q   <= outstanding_d;
      rd_valid_q      <= rd_valid_d;
      swapped_q       <= swapped_d;
    end
  end

  assign m_rd_valid    = rd_valid_q;
  assign m_rd_addr     = line_addr_q;
  assign m_rd_len      = LINE_BYTES(X_RES);
  assign fb_swapped    = swapped_q;
  assign busy          = (state_q != SEQ_IDLE);
  assign m_axis_tvalid = s_pix_tvalid;
  assign s_pix_tready  = m_axis_tready;
  assign m_axis_tdata  = s_pix_tdata;
  assign m_axis_tlast  = (pix_row == ROW_W'(Y_RES - 1)) && (pix_col == COL_W'(X_RES - 1));

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Directed scenario sequence with randomized handshakes, checked against a frame-level model
// of line addresses, pixel order, tlast positions, swap pulses and lines in flight.
module tb_display_frame_sequencer;

  localparam int XRes        = 8;
  localparam int YRes        = 6;
  localparam int AddrW       = 32;
  localparam int MaxOut      = 2;
  localparam int LineBytes   = XRes * 2;
  localparam int PixPerFrame = XRes * YRes;
  localparam int Budget      = 3000;

  logic             aclk = 1'b0;
  logic             resetn, enable, fb_swap, fb_swapped, busy;
  logic             m_rd_valid, m_rd_ready;
  logic [AddrW-1:0] fb_addr, m_rd_addr;
  logic [15:0]      m_rd_len, s_pix_tdata, m_axis_tdata;
  logic             s_pix_tvalid, s_pix_tready, m_axis_tvalid, m_axis_tready, m_axis_tlast;

  int checkCount = 0;
  int passCount  = 0;

  int readyMode, srcMode, sinkMode;
  int linesPending, pixInLine, srcSerial, sinkSerial, pixIdx, linesDone;
  int cmdCount, cmdInFrame, tlastCount, swapCount;
  logic [AddrW-1:0] expNextBase, frameBase, prevAddr;
  logic             prevStall;

  display_frame_sequencer #(
    .X_RES          (XRes),
    .Y_RES          (YRes),
    .ADDR_WIDTH     (AddrW),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .aclk         (aclk),
    .resetn       (resetn),
    .enable       (enable),
    .fb_addr      (fb_addr),
    .fb_swap      (fb_swap),
    .fb_swapped   (fb_swapped),
    .busy         (busy),
    .m_rd_valid   (m_rd_valid),
    .m_rd_ready   (m_rd_ready),
    .m_rd_addr    (m_rd_addr),
    .m_rd_len     (m_rd_len),
    .s_pix_tvalid (s_pix_tvalid),
    .s_pix_tready (s_pix_tready),
    .s_pix_tdata  (s_pix_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdata (m_axis_tdata)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clearModel();
    linesPending = 0; pixInLine = 0; srcSerial = 0; sinkSerial = 0;
    pixIdx = 0; linesDone = 0; cmdCount = 0; cmdInFrame = 0;
    tlastCount = 0; swapCount = 0; prevStall = 1'b0; prevAddr = '0; frameBase = '0;
  endtask

  // Called just before each rising edge, so every handshake seen here completes on that edge.
  task automatic sampleCycle();
    logic expLast;
    if (resetn !== 1'b1) return;
    checkOutput("tvalid_pass", m_axis_tvalid, s_pix_tvalid);
    checkOutput("tready_pass", s_pix_tready, m_axis_tready);
    checkOutput("rd_len", m_rd_len, LineBytes);
    if (prevStall) begin
      checkOutput("rd_valid_hold", m_rd_valid, 1);
      checkOutput("rd_addr_hold", m_rd_addr, prevAddr);
    end
    prevStall = m_rd_valid && !m_rd_ready;
    prevAddr  = m_rd_addr;
    if (m_rd_valid && m_rd_ready) begin
      if (cmdInFrame == 0) frameBase = expNextBase;
      checkOutput("rd_addr", m_rd_addr, frameBase + 32'(cmdInFrame * LineBytes));
      checkOutput("in_flight_below_max", 32'(cmdCount - linesDone < MaxOut), 1);
      cmdCount++;
      cmdInFrame = (cmdInFrame == YRes - 1) ? 0 : cmdInFrame + 1;
      linesPending++;
    end
    if (s_pix_tvalid && s_pix_tready) begin
      srcSerial++;
      pixInLine++;
      if (pixInLine == XRes) begin
        pixInLine = 0;
        linesPending--;
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      expLast = ((pixIdx % PixPerFrame) == PixPerFrame - 1);
      checkOutput("tdata_order", m_axis_tdata, 16'(sinkSerial));
      checkOutput("tlast_pos", m_axis_tlast, expLast);
      if (m_axis_tlast) tlastCount++;
      sinkSerial++;
      pixIdx++;
      linesDone = pixIdx / XRes;
    end
    if (fb_swapped === 1'b1) swapCount++;
  endtask

  // Reader and display-controller side: drive on the falling edge, sample 1 ns later.
  initial begin : bfm
    forever begin
      @(negedge aclk);
      case (readyMode)
        0:       m_rd_ready = 1'b1;
        1:       m_rd_ready = ($urandom_range(0, 1) == 1);
        default: m_rd_ready = 1'b0;
      endcase
      m_axis_tready = (sinkMode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      s_pix_tvalid  = (linesPending > 0) && (srcMode == 0 || $urandom_range(0, 3) == 0);
      s_pix_tdata   = 16'(srcSerial);
      #1;
      sampleCycle();
    end
  end

  task automatic tick();
    @(negedge aclk);
    #2;
  endtask

  task automatic applyStimulus(input logic [AddrW-1:0] addr);
    @(negedge aclk);
    fb_addr = addr;
    fb_swap = 1'b1;
    @(negedge aclk);
    fb_swap = 1'b0;
  endtask

  task automatic waitTlast(input int target, input string tag);
    int n = 0;
    while (tlastCount < target && n < Budget) begin
      tick();
      n++;
    end
    checkOutput(tag, tlastCount, target);
  endtask

  task automatic waitPixInFrame(input int minPix, input string tag);
    int n = 0;
    while ((pixIdx % PixPerFrame) < minPix && n < Budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'((pixIdx % PixPerFrame) >= minPix), 1);
  endtask

  task automatic waitCmdInFrame(input int target, input string tag);
    int n = 0;
    while (cmdInFrame != target && n < Budget) begin
      tick();
      n++;
    end
    checkOutput(tag, cmdInFrame, target);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rd_valid"}, m_rd_valid, 0);
    checkOutput({tag, "_rd_addr"}, m_rd_addr, 0);
    checkOutput({tag, "_swapped"}, fb_swapped, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_tlast"}, m_axis_tlast, 0);
  endtask

  initial begin : main
    int t, c;
    resetn = 1'b1; enable = 1'b0; fb_swap = 1'b0; fb_addr = '0;
    m_rd_ready = 1'b0; m_axis_tready = 1'b0; s_pix_tvalid = 1'b0; s_pix_tdata = '0;
    readyMode = 0; srcMode = 0; sinkMode = 0; expNextBase = '0;
    clearModel();
    #1 resetn = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (3) @(negedge aclk);
    resetn = 1'b1;

    // Enabled but no framebuffer yet: must stay idle.
    enable = 1'b1;
    repeat (10) tick();
    checkOutput("idle_without_fb_busy", busy, 0);
    checkOutput("idle_without_fb_cmds", cmdCount, 0);

    // First frame from 0x1000 with everything always ready.
    expNextBase = 32'h1000;
    applyStimulus(32'h1000);
    waitTlast(1, "frame1_tlast");
    checkOutput("frame1_cmds", cmdCount, YRes);
    checkOutput("frame1_swaps", swapCount, 1);

    // Command stall for 10 cycles while the reader trickles pixels back.
    srcMode = 1;
    readyMode = 2;
    repeat (10) tick();
    readyMode = 1;
    waitTlast(2, "frame2_tlast");
    checkOutput("frame2_cmds", cmdCount, 2 * YRes);

    // Two swaps mid-frame: the current frame keeps its base, the next one uses the last swap.
    sinkMode = 1;
    waitCmdInFrame(2, "midframe_reached");
    t = tlastCount;
    @(negedge aclk);
    fb_addr = 32'h2000;
    fb_swap = 1'b1;
    @(negedge aclk);
    fb_addr = 32'h3000;
    @(negedge aclk);
    fb_swap = 1'b0;
    expNextBase = 32'h3000;
    waitTlast(t + 2, "swap_frames_tlast");
    checkOutput("swap_pulses", swapCount, 2);

    // Drop enable around row 3: the frame completes, then the block goes idle.
    waitPixInFrame(3 * XRes, "row3_reached");
    enable = 1'b0;
    t = tlastCount;
    waitTlast(t + 1, "enable_drop_tlast");
    repeat (5) tick();
    checkOutput("enable_drop_busy", busy, 0);
    checkOutput("enable_drop_frame_whole", pixIdx % PixPerFrame, 0);
    c = cmdCount;
    repeat (20) tick();
    checkOutput("enable_drop_no_cmds", cmdCount, c);
    checkOutput("enable_drop_rd_valid", m_rd_valid, 0);

    // Restart from the held base, then reset in the middle of the frame.
    sinkMode = 0; srcMode = 0; readyMode = 0;
    c = swapCount;
    enable = 1'b1;
    waitPixInFrame(3 * XRes, "restart_row3");
    checkOutput("restart_no_swap_pulse", swapCount, c);
    @(negedge aclk);
    #3;
    resetn = 1'b0;
    clearModel();
    s_pix_tvalid = 1'b0;
    #1 checkResetOutputs("midframe_reset");
    repeat (3) @(negedge aclk);
    resetn = 1'b1;
    repeat (8) tick();
    checkOutput("post_reset_idle_busy", busy, 0);
    checkOutput("post_reset_idle_cmds", cmdCount, 0);

    expNextBase = 32'h4000;
    applyStimulus(32'h4000);
    waitTlast(1, "post_reset_frame_tlast");
    checkOutput("post_reset_swaps", swapCount, 1);
    checkOutput("post_reset_cmds", cmdCount, YRes);
    enable = 1'b0;
    repeat (20) tick();
    checkOutput("final_busy", busy, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
